// File: rtl/rf_sequencer.sv
// Command sequencer for the RF register file: turns one host command into the
// cycle-by-cycle O1Sel/O2Sel/FunSel/RSel/TSel/i control pattern.
module rf_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [2:0]       cmd_dst,
   input  logic [2:0]       cmd_src,
   input  logic [WIDTH-1:0] cmd_imm,
   input  logic [CNT_W-1:0] cmd_cnt,
   output logic             done,
   output logic             err,
   output logic [2:0]       O1Sel,
   output logic [2:0]       O2Sel,
   output logic [1:0]       FunSel,
   output logic [3:0]       RSel,
   output logic [3:0]       TSel,
   output logic [WIDTH-1:0] i,
   input  logic [WIDTH-1:0] O1,
   input  logic [WIDTH-1:0] O2
);

   localparam logic [2:0] OP_CLR = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_INC = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_MOV = 3'b100;

   localparam logic [1:0] FN_CLR  = 2'b00;
   localparam logic [1:0] FN_LOAD = 2'b01;
   localparam logic [1:0] FN_DEC  = 2'b10;
   localparam logic [1:0] FN_INC  = 2'b11;

   localparam logic [CNT_W:0] L_FULL = {1'b1, {CNT_W{1'b0}}};
   localparam logic [CNT_W:0] L_ONE  = {{CNT_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t           r_state;
   logic [2:0]       r_op;
   logic [2:0]       r_dst;
   logic [CNT_W:0]   r_cnt;
   logic [WIDTH-1:0] r_hold;
   logic             r_ready;
   logic             r_done;
   logic             r_err;
   logic [2:0]       r_o1sel;
   logic [2:0]       r_o2sel;
   logic [1:0]       r_funsel;
   logic [3:0]       r_rsel;
   logic [3:0]       r_tsel;

   // O2 is a host-side monitor path only
   logic w_unused;
   assign w_unused = ^O2;

   function automatic logic [3:0] f_onehot(input logic [1:0] sel);
      return 4'b1000 >> sel;
   endfunction

   function automatic logic [1:0] f_fun(input logic [2:0] op);
      case (op)
         OP_LDI, OP_MOV: return FN_LOAD;
         OP_INC:         return FN_INC;
         OP_DEC:         return FN_DEC;
         default:        return FN_CLR;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= OP_CLR;
         r_dst    <= 3'b000;
         r_cnt    <= '0;
         r_hold   <= '0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_o1sel  <= 3'b000;
         r_o2sel  <= 3'b000;
         r_funsel <= FN_CLR;
         r_rsel   <= 4'b0000;
         r_tsel   <= 4'b0000;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_ready <= 1'b0;
                  r_op    <= cmd_op;
                  r_dst   <= cmd_dst;
                  r_o2sel <= cmd_dst;
                  r_cnt   <= (cmd_cnt == '0) ? L_FULL : {1'b0, cmd_cnt};
                  if (cmd_op == OP_MOV) begin
                     r_o1sel <= cmd_src;
                     r_state <= S_READ;
                  end else if (cmd_op > OP_MOV) begin
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     // Outputs are registered, so the first write pattern is set up here
                     r_funsel <= f_fun(cmd_op);
                     if (cmd_dst[2]) r_rsel <= f_onehot(cmd_dst[1:0]);
                     else            r_tsel <= f_onehot(cmd_dst[1:0]);
                     r_hold  <= (cmd_op == OP_LDI) ? cmd_imm : '0;
                     r_state <= S_WRITE;
                  end
               end
            end
            S_READ: begin
               r_hold   <= O1;
               r_funsel <= FN_LOAD;
               if (r_dst[2]) r_rsel <= f_onehot(r_dst[1:0]);
               else          r_tsel <= f_onehot(r_dst[1:0]);
               r_state  <= S_WRITE;
            end
            S_WRITE: begin
               if ((r_op == OP_INC || r_op == OP_DEC) && r_cnt != L_ONE) begin
                  r_cnt <= r_cnt - L_ONE;
               end else begin
                  r_rsel   <= 4'b0000;
                  r_tsel   <= 4'b0000;
                  r_funsel <= FN_CLR;
                  r_hold   <= '0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign done      = r_done;
   assign err       = r_err;
   assign O1Sel     = r_o1sel;
   assign O2Sel     = r_o2sel;
   assign FunSel    = r_funsel;
   assign RSel      = r_rsel;
   assign TSel      = r_tsel;
   assign i         = r_hold;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer: a behavioural RF answers the DUT, a
// reference register array predicts each command's result and timing.
module tb_rf_sequencer;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0, cmd_dst = '0, cmd_src = '0;
   logic [WIDTH-1:0] cmd_imm = '0;
   logic [CNT_W-1:0] cmd_cnt = '0;
   logic             done, err;
   logic [2:0]       O1Sel, O2Sel;
   logic [1:0]       FunSel;
   logic [3:0]       RSel, TSel;
   logic [WIDTH-1:0] i, O1, O2;

   always #5 clk = ~clk;

   rf_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
      .cmd_cnt(cmd_cnt), .done(done), .err(err), .O1Sel(O1Sel), .O2Sel(O2Sel),
      .FunSel(FunSel), .RSel(RSel), .TSel(TSel), .i(i), .O1(O1), .O2(O2)
   );

   // Behavioural register file, indexed by register code (0..3 T1..T4, 4..7 R1..R4)
   logic [WIDTH-1:0] rf [8];
   logic [7:0]       en8;
   assign en8 = {RSel[0], RSel[1], RSel[2], RSel[3], TSel[0], TSel[1], TSel[2], TSel[3]};
   assign O1 = rf[O1Sel];
   assign O2 = rf[O2Sel];

   always @(posedge clk) begin
      for (int c = 0; c < 8; c++) begin
         if (en8[c]) begin
            case (FunSel)
               2'b00: rf[c] <= '0;
               2'b01: rf[c] <= i;
               2'b10: rf[c] <= rf[c] - 1'b1;
               default: rf[c] <= rf[c] + 1'b1;
            endcase
         end
      end
   end

   typedef struct {
      logic [2:0]       op, dst, src;
      logic [1:0]       fun;
      logic [3:0]       rsel, tsel;
      logic [WIDTH-1:0] exp_i, exp_val;
      int               lat, wr;
      logic             is_err;
   } txn_t;

   txn_t             q[$];
   txn_t             mt;
   logic [WIDTH-1:0] ref_rf [8];
   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;
   bit busy = 1'b0;
   int cyc = 0;
   int wr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accept edge.
   task automatic send(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [WIDTH-1:0] imm, input logic [CNT_W-1:0] cnt);
      txn_t t;
      int   n;
      int   k;
      n = (cnt == 0) ? (1 << CNT_W) : int'(cnt);
      t.op = op; t.dst = dst; t.src = src; t.is_err = 1'b0;
      t.rsel = dst[2] ? 4'(1 << (3 - int'(dst[1:0]))) : 4'b0000;
      t.tsel = dst[2] ? 4'b0000 : 4'(1 << (3 - int'(dst[1:0])));
      t.exp_i = '0;
      case (op)
         3'd0: begin t.fun = 2'b00; t.lat = 2; t.wr = 1; ref_rf[dst] = '0; end
         3'd1: begin t.fun = 2'b01; t.lat = 2; t.wr = 1; t.exp_i = imm; ref_rf[dst] = imm; end
         3'd2: begin t.fun = 2'b11; t.lat = n + 1; t.wr = n; ref_rf[dst] = ref_rf[dst] + WIDTH'(n); end
         3'd3: begin t.fun = 2'b10; t.lat = n + 1; t.wr = n; ref_rf[dst] = ref_rf[dst] - WIDTH'(n); end
         3'd4: begin t.fun = 2'b01; t.lat = 3; t.wr = 1; t.exp_i = ref_rf[src]; ref_rf[dst] = ref_rf[src]; end
         default: begin t.fun = 2'b00; t.lat = 1; t.wr = 0; t.is_err = 1'b1; end
      endcase
      t.exp_val = ref_rf[dst];
      cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm; cmd_cnt = cnt;
      cmd_valid = 1'b1;
      q.push_back(t);
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         $display("FAIL accept_timeout: sequencer never became ready");
         $fatal(1, "accept bound expired");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Monitor: checks every cycle of the current command, pops on done
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (busy) begin
            cyc++;
            mt = q[0];
            check("ready_busy", {31'd0, cmd_ready}, 32'd0);
            check("o2sel_dst", {29'd0, O2Sel}, {29'd0, mt.dst});
            if (en8 != 8'h00) begin
               wr++;
               check("write_ctl", {18'd0, FunSel, RSel, TSel, i}, {18'd0, mt.fun, mt.rsel, mt.tsel, mt.exp_i});
            end
            if (mt.op == 3'd4 && cyc == 1)
               check("mov_read", {21'd0, O1Sel, en8}, {21'd0, mt.src, 8'h00});
            if (done) begin
               void'(q.pop_front());
               check("latency", cyc, mt.lat);
               check("write_count", wr, mt.wr);
               check("err_flag", {31'd0, err}, {31'd0, mt.is_err});
               if (!mt.is_err) check("result_o2", {24'd0, O2}, {24'd0, mt.exp_val});
               $display("txn op=%0d dst=%0d src=%0d lat=%0d writes=%0d err=%0b val=%02h",
                        mt.op, mt.dst, mt.src, cyc, wr, err, O2);
               busy = 1'b0;
            end else if (cyc > mt.lat) begin
               check("done_timeout", cyc, mt.lat);
               void'(q.pop_front());
               busy = 1'b0;
            end
         end else begin
            check("idle_quiet", {22'd0, done, err, en8}, 32'd0);
            if (cmd_valid && cmd_ready) begin
               if (q.size() == 0) begin
                  check("queue_empty", 32'd0, 32'd1);
               end else begin
                  busy = 1'b1;
                  cyc = 0;
                  wr = 0;
               end
            end
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] orig;
      logic [2:0]       op;
      int               k;

      #12;
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_pulses", {30'd0, done, err}, 32'd0);
      check("rst_sel", {24'd0, O1Sel, O2Sel, FunSel}, 32'd0);
      check("rst_en_i", {16'd0, RSel, TSel, i}, 32'd0);
      #10 rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      for (int c = 0; c < 8; c++) send(3'd1, 3'(c), 3'd0, WIDTH'($urandom), 4'd0);
      send(3'd1, 3'b100, 3'd0, 8'h14, 4'd0);
      send(3'd1, 3'b011, 3'd0, 8'hFE, 4'd0);
      send(3'd2, 3'b011, 3'd0, 8'h00, 4'd3);
      send(3'd1, 3'b101, 3'd0, 8'h5A, 4'd0);
      send(3'd4, 3'b001, 3'b101, 8'h00, 4'd0);
      send(3'd1, 3'b110, 3'd0, 8'h20, 4'd0);
      send(3'd3, 3'b110, 3'd0, 8'h00, 4'd0);
      send(3'b110, 3'b010, 3'd0, 8'h00, 4'd0);
      send(3'd4, 3'b111, 3'b111, 8'h00, 4'd0);

      for (int n = 0; n < 60; n++) begin
         op = 3'($urandom_range(0, 7));
         send(op, 3'($urandom), 3'($urandom), WIDTH'($urandom), 4'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      k = 0;
      while ((busy || q.size() != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("drain", {31'd0, busy}, 32'd0);

      // Reset in the middle of INC cnt=8 on R3, after two writes have landed
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      orig = ref_rf[6];
      cmd_op = 3'd2; cmd_dst = 3'b110; cmd_cnt = 4'd8; cmd_valid = 1'b1;
      @(negedge clk);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_writing", {28'd0, RSel}, 32'h2);
      rst_n = 1'b0;
      #1;
      check("abort_en_drop", {24'd0, RSel, TSel}, 32'd0);
      check("abort_rst_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", {30'd0, done, err}, 32'd0);
      end
      check("abort_value", {24'd0, rf[6]}, {24'd0, orig + 8'd2});
      ref_rf[6] = orig + 8'd2;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_done_low", {31'd0, done}, 32'd0);
      check("after_rst_ready", {31'd0, cmd_ready}, 32'd1);
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      send(3'd1, 3'b010, 3'd0, 8'hC3, 4'd0);
      send(3'd4, 3'b000, 3'b110, 8'h00, 4'd0);
      send(3'd0, 3'b110, 3'd0, 8'h00, 4'd0);

      k = 0;
      while ((busy || q.size() != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("final_drain", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
